// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding,
// arbitration mode values and requestor port identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Requestor ids double as bit positions in the two-bit request vector
    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    // Width of the read-latency countdown; bounds MEM_LATENCY to 1..15
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Two-way combinational arbiter. A lone requester always wins; on
// contention, fixed mode favours DATA and round-robin mode favours the
// port that was not granted last.
module arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       mode,
    output logic [1:0] grant
);

    // One-hot winner selection from the request vector
    always_comb begin
        grant = 2'b00;
        if (req[FETCH] && req[DATA]) begin
            if (mode && (rr_last == DATA)) begin
                grant[FETCH] = 1'b1;
            end else begin
                grant[DATA] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// data port. Writes are posted (granted and retired in one cycle); reads
// hold the arbiter until the memory data is returned to the issuing port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int MEM_LATENCY = 1,
    parameter  int ARB_MODE    = 0,
    localparam int NB          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [NB-1:0]     d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NB-1:0]     mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Elaboration-time parameter sanity checks
    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("mem_arbiter: MEM_LATENCY must lie in 1..15");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_width
            $error("mem_arbiter: DATA_W must be a multiple of 8");
        end
    endgenerate

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = 4'(MEM_LATENCY);
    localparam logic                 RR_MODE  = (ARB_MODE == ARB_RR);

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic                   owner_q, owner_d;
    logic                   rr_last_q, rr_last_d;

    logic [1:0]             req_vec;
    logic [1:0]             grant_vec;
    logic                   in_idle;

    assign req_vec = {d_req, if_req};

    arb2 u_arb2 (
        .req     (req_vec),
        .rr_last (rr_last_q),
        .mode    (RR_MODE),
        .grant   (grant_vec)
    );

    // Grants and memory command; grants only in IDLE and never while reset
    // is held low, so all strobes drop the instant reset asserts
    always_comb begin
        in_idle   = (state_q == IDLE);
        if_gnt    = reset & in_idle & grant_vec[FETCH];
        d_gnt     = reset & in_idle & grant_vec[DATA];
        mem_req   = if_gnt | d_gnt;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Read response steering: memory data passes straight through to the owner
    always_comb begin
        if_rvalid = (state_q == RESP) && (owner_q == FETCH);
        d_rvalid  = (state_q == RESP) && (owner_q == DATA);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
        busy      = (state_q != IDLE);
    end

    // Next-state logic for the FSM, latency counter, owner and rr pointer
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    rr_last_d = d_gnt ? DATA : FETCH;
                    // A posted write leaves the arbiter free next cycle
                    if (!(d_gnt && (d_we != '0))) begin
                        owner_d   = d_gnt ? DATA : FETCH;
                        lat_cnt_d = LAT_INIT;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; an outstanding read is simply abandoned on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            owner_q   <= FETCH;
            rr_last_q <= FETCH;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 / fixed priority and
// latency 3 / round-robin) each with a small behavioural memory. Read
// expectations are queued at grant time and retired by a response monitor.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic [31:0]   due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cyc = '0;

    always #5 clk = ~clk;

    // Cycle index used to timestamp grants and responses
    always @(posedge clk) cyc <= cyc + 32'd1;

    logic [1:0]    if_req, d_req, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, busy;
    logic [AW-1:0] if_addr [2];
    logic [AW-1:0] d_addr [2];
    logic [AW-1:0] mem_addr [2];
    logic [NB-1:0] d_we [2];
    logic [NB-1:0] mem_we [2];
    logic [DW-1:0] d_wdata [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] if_rdata [2];
    logic [DW-1:0] d_rdata [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int mode_of(input int i);
        return (i == 0) ? ARB_FIXED : ARB_RR;
    endfunction

    // Contents of the behavioural memory
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'd7) ^ 32'hC0DE_0000;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT  = (gi == 0) ? 1 : 3;
            localparam int MODE = (gi == 0) ? 0 : 1;
            logic [DW-1:0] mrd;
            logic          cur_v, tap_v;
            logic [AW-1:0] cur_a, tap_a;
            logic          pv [1:15];
            logic [AW-1:0] pa [1:15];

            assign cur_v = mem_req[gi] && (mem_we[gi] == '0);
            assign cur_a = mem_addr[gi];

            // Read-command delay line modelling the memory pipeline
            always @(posedge clk) begin
                pv[1] <= cur_v;
                pa[1] <= cur_a;
                for (int k = 2; k <= 15; k++) begin
                    pv[k] <= pv[k-1];
                    pa[k] <= pa[k-1];
                end
            end

            if (LAT == 1) begin : g_l1
                assign tap_v = cur_v;
                assign tap_a = cur_a;
            end else begin : g_ln
                assign tap_v = pv[LAT-1];
                assign tap_a = pa[LAT-1];
            end

            // Read data appears LAT cycles after the command and is held
            always @(posedge clk) if (tap_v) mrd <= mem_fn(tap_a);

            mem_arbiter #(
                .ADDR_W      (AW),
                .DATA_W      (DW),
                .MEM_LATENCY (LAT),
                .ARB_MODE    (MODE)
            ) u_dut (
                .clk       (clk),
                .reset     (rst_n),
                .if_req    (if_req[gi]),
                .if_addr   (if_addr[gi]),
                .if_gnt    (if_gnt[gi]),
                .if_rvalid (if_rvalid[gi]),
                .if_rdata  (if_rdata[gi]),
                .d_req     (d_req[gi]),
                .d_addr    (d_addr[gi]),
                .d_we      (d_we[gi]),
                .d_wdata   (d_wdata[gi]),
                .d_gnt     (d_gnt[gi]),
                .d_rvalid  (d_rvalid[gi]),
                .d_rdata   (d_rdata[gi]),
                .mem_req   (mem_req[gi]),
                .mem_addr  (mem_addr[gi]),
                .mem_we    (mem_we[gi]),
                .mem_wdata (mem_wdata[gi]),
                .mem_rdata (mrd),
                .busy      (busy[gi])
            );
        end
    endgenerate

    // Response monitor: every rvalid must retire the oldest queued read
    always @(negedge clk) begin
        logic          port;
        logic [DW-1:0] data;
        exp_t          e;
        for (int i = 0; i < 2; i++) begin
            if (if_rvalid[i] && d_rvalid[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dual_rvalid[%0d]: both rvalid high at cycle %0d, required at most one", i, cyc);
            end
            if (if_rvalid[i] || d_rvalid[i]) begin
                port = d_rvalid[i];
                data = port ? d_rdata[i] : if_rdata[i];
                n_cmp++;
                if (qsize(i) == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rvalid[%0d]: port=%0d data=%h at cycle %0d, required no response", i, port, data, cyc);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (port !== e.port || data !== e.data || cyc !== e.due) begin
                        n_bad++;
                        $display("FAIL response[%0d]: got port=%0d data=%h cycle=%0d, required port=%0d data=%h cycle=%0d",
                                 i, port, data, cyc, e.port, e.data, e.due);
                    end else begin
                        $display("resp[%0d] port=%0d data=%h cycle=%0d ok", i, port, data, cyc);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int i, input logic port, input logic [AW-1:0] addr);
        exp_t e;
        e.port = port;
        e.data = mem_fn(addr);
        e.due  = cyc + 32'(lat_of(i)) + 32'd1;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int i);
        if_req[i]  = 1'b0;
        d_req[i]   = 1'b0;
        if_addr[i] = '0;
        d_addr[i]  = '0;
        d_we[i]    = '0;
        d_wdata[i] = '0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        if_req = 2'b11;
        d_req  = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({if_gnt[i], d_gnt[i], mem_req[i], busy[i], if_rvalid[i], d_rvalid[i]} !== 6'b0
                || mem_we[i] !== '0 || mem_addr[i] !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: gnt=%b%b req=%b busy=%b rv=%b%b we=%b addr=%h, required all 0",
                         i, if_gnt[i], d_gnt[i], mem_req[i], busy[i], if_rvalid[i], d_rvalid[i], mem_we[i], mem_addr[i]);
            end
            quiet(i);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        next_cycle();
        $display("reset check done");
    endtask

    task automatic test_arb(input int i);
        int   grants = 0;
        logic got;
        logic want;
        if_req[i]  = 1'b1;
        if_addr[i] = 32'h200;
        d_req[i]   = 1'b1;
        d_addr[i]  = 32'h300;
        d_we[i]    = '0;
        for (int k = 0; k < 60 && grants < 4; k++) begin
            @(negedge clk);
            if (if_gnt[i] || d_gnt[i]) begin
                got  = d_gnt[i];
                want = (mode_of(i) == ARB_FIXED) ? DATA : (((grants % 2) == 0) ? DATA : FETCH);
                n_cmp++;
                if ((if_gnt[i] && d_gnt[i]) || got !== want) begin
                    n_bad++;
                    $display("FAIL arb_order[%0d] grant %0d: got if_gnt=%b d_gnt=%b, required port %0d", i, grants, if_gnt[i], d_gnt[i], want);
                end else begin
                    $display("arb[%0d] grant %0d port=%0d ok", i, grants, got);
                end
                push_exp(i, got, got ? d_addr[i] : if_addr[i]);
                grants++;
            end
            @(posedge clk);
            #1;
        end
        quiet(i);
        n_cmp++;
        if (grants != 4) begin
            n_bad++;
            $display("FAIL arb_grants[%0d]: got %0d grants, required 4", i, grants);
        end
        for (int k = 0; k < 30 && qsize(i) != 0; k++) next_cycle();
        n_cmp++;
        if (qsize(i) != 0) begin
            n_bad++;
            $display("FAIL arb_drain[%0d]: %0d reads unanswered, required 0", i, qsize(i));
        end
    endtask

    task automatic test_fetch_read();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (if_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0 || mem_req[0] !== 1'b1
            || mem_addr[0] !== 32'h100 || mem_we[0] !== '0) begin
            n_bad++;
            $display("FAIL fetch_grant: if_gnt=%b d_gnt=%b mem_req=%b addr=%h we=%b, required 1 0 1 00000100 0000",
                     if_gnt[0], d_gnt[0], mem_req[0], mem_addr[0], mem_we[0]);
        end
        if (if_gnt[0]) push_exp(0, FETCH, 32'h100);
        next_cycle();
        quiet(0);
        @(negedge clk);
        n_cmp++;
        if (if_gnt[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_wait: if_gnt=%b busy=%b, required 0 1", if_gnt[0], busy[0]);
        end
        next_cycle();
        for (int k = 0; k < 10 && qsize(0) != 0; k++) next_cycle();
        n_cmp++;
        if (qsize(0) != 0) begin
            n_bad++;
            $display("FAIL fetch_drain: %0d reads unanswered, required 0", qsize(0));
        end
    endtask

    task automatic test_write_b2b();
        logic [NB-1:0] we_tab [2];
        logic [DW-1:0] wd_tab [2];
        logic [AW-1:0] ad_tab [2];
        we_tab = '{4'b0011, 4'b1100};
        wd_tab = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
        ad_tab = '{32'h40, 32'h44};
        for (int w = 0; w < 2; w++) begin
            d_req[0]   = 1'b1;
            d_addr[0]  = ad_tab[w];
            d_we[0]    = we_tab[w];
            d_wdata[0] = wd_tab[w];
            @(negedge clk);
            n_cmp++;
            if (d_gnt[0] !== 1'b1 || mem_req[0] !== 1'b1 || mem_we[0] !== we_tab[w]
                || mem_wdata[0] !== wd_tab[w] || mem_addr[0] !== ad_tab[w] || busy[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL write_%0d: gnt=%b req=%b we=%b wdata=%h addr=%h busy=%b, required 1 1 %b %h %h 0",
                         w, d_gnt[0], mem_req[0], mem_we[0], mem_wdata[0], mem_addr[0], busy[0], we_tab[w], wd_tab[w], ad_tab[w]);
            end else begin
                $display("write %0d we=%b data=%h ok", w, mem_we[0], mem_wdata[0]);
            end
            next_cycle();
        end
        quiet(0);
        @(negedge clk);
        n_cmp++;
        if (mem_req[0] !== 1'b0 || mem_we[0] !== '0 || mem_addr[0] !== '0) begin
            n_bad++;
            $display("FAIL write_idle: mem_req=%b we=%b addr=%h, required 0", mem_req[0], mem_we[0], mem_addr[0]);
        end
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_latency();
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h500;
        @(negedge clk);
        n_cmp++;
        if (d_gnt[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL lat_dgnt: d_gnt=%b, required 1", d_gnt[1]);
        end
        if (d_gnt[1]) push_exp(1, DATA, 32'h500);
        next_cycle();
        quiet(1);
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h104;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            n_cmp++;
            if (if_gnt[1] !== 1'b0 || (t <= 3 && busy[1] !== 1'b1)) begin
                n_bad++;
                $display("FAIL lat_t%0d: if_gnt=%b busy=%b, required gnt 0 busy %0d", t, if_gnt[1], busy[1], (t <= 3));
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (if_gnt[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_t5: if_gnt=%b busy=%b, required 1 0", if_gnt[1], busy[1]);
        end
        if (if_gnt[1]) push_exp(1, FETCH, 32'h104);
        next_cycle();
        quiet(1);
        for (int k = 0; k < 20 && qsize(1) != 0; k++) next_cycle();
        n_cmp++;
        if (qsize(1) != 0) begin
            n_bad++;
            $display("FAIL lat_drain: %0d reads unanswered, required 0", qsize(1));
        end
    endtask

    task automatic test_reset_mid_read();
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h700;
        @(negedge clk);
        n_cmp++;
        if (d_gnt[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_read_gnt: d_gnt=%b, required 1", d_gnt[1]);
        end
        next_cycle();
        quiet(1);
        @(negedge clk);
        n_cmp++;
        if (busy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_busy_before: busy=%b, required 1", busy[1]);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        if_req[1] = 1'b1;
        #1;
        n_cmp++;
        if (busy[1] !== 1'b0 || if_gnt[1] !== 1'b0 || mem_req[1] !== 1'b0 || d_rvalid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: busy=%b if_gnt=%b mem_req=%b d_rvalid=%b, required all 0",
                     busy[1], if_gnt[1], mem_req[1], d_rvalid[1]);
        end
        if_req[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_rvalid[1] !== 1'b0 || d_rvalid[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_no_rvalid: if_rvalid=%b d_rvalid=%b, required 0 0", if_rvalid[1], d_rvalid[1]);
            end
            next_cycle();
        end
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h108;
        @(negedge clk);
        n_cmp++;
        if (if_gnt[1] !== 1'b1 || mem_addr[1] !== 32'h108) begin
            n_bad++;
            $display("FAIL rst_regrant: if_gnt=%b addr=%h, required 1 00000108", if_gnt[1], mem_addr[1]);
        end
        if (if_gnt[1]) push_exp(1, FETCH, 32'h108);
        next_cycle();
        quiet(1);
        for (int k = 0; k < 20 && qsize(1) != 0; k++) next_cycle();
        n_cmp++;
        if (qsize(1) != 0) begin
            n_bad++;
            $display("FAIL rst_drain: %0d reads unanswered, required 0", qsize(1));
        end
    endtask

    task automatic test_withdraw();
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h600;
        @(negedge clk);
        n_cmp++;
        if (d_gnt[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_dgnt: d_gnt=%b, required 1", d_gnt[0]);
        end
        if (d_gnt[0]) push_exp(0, DATA, 32'h600);
        next_cycle();
        quiet(0);
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h108;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            n_cmp++;
            if (if_gnt[0] !== 1'b0 || mem_req[0] !== 1'b0 || mem_addr[0] !== '0) begin
                n_bad++;
                $display("FAIL wd_t%0d: if_gnt=%b mem_req=%b addr=%h, required 0 0 0", t, if_gnt[0], mem_req[0], mem_addr[0]);
            end
            next_cycle();
            if_req[0] = 1'b0;
        end
        for (int k = 0; k < 10 && qsize(0) != 0; k++) next_cycle();
        n_cmp++;
        if (qsize(0) != 0) begin
            n_bad++;
            $display("FAIL wd_drain: %0d reads unanswered, required 0", qsize(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        quiet(0);
        quiet(1);
        test_reset();
        test_arb(0);
        test_arb(1);
        test_fetch_read();
        test_write_b2b();
        test_latency();
        test_reset_mid_read();
        test_withdraw();
        next_cycle();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
